dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the CPU load/store unit (cpu_*) and a debug/loader master (dbg_*).
- The loader preloads or inspects memory while the core runs.
- Sits between cpu and the dmem interface instance in the top level. Arbitration is round-robin, with a bounded bus-lock for debug bursts.
- Memory accepts one access per cycle and returns read data exactly 1 cycle after acceptance.

Parameters:
XLEN, 32, data width in bits
ADDR_W, 32, byte-address width
LOCK_MAX, 16, max consecutive dbg grants under lock before one forced CPU slot (>=1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
cpu_req_i / dbg_req_i  input  1  access request; held until granted
cpu_we_i / dbg_we_i  input  1  1 = write, 0 = read
cpu_be_i / dbg_be_i  input  XLEN/8  byte enables
cpu_addr_i / dbg_addr_i  input  ADDR_W  byte address
cpu_wdata_i / dbg_wdata_i  input  XLEN  write data
dbg_lock_i  input  1  dbg requests exclusive ownership while asserted
cpu_gnt_o / dbg_gnt_o  output  1  request accepted this cycle
cpu_rvalid_o / dbg_rvalid_o  output  1  read data valid (1 cycle after read grant)
cpu_rdata_o / dbg_rdata_o  output  XLEN  read data, copy of mem_rdata_i
mem_req_o  output  1  access issued to dmem this cycle
mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  output  1/XLEN/8/ADDR_W/XLEN  muxed winner fields
mem_rdata_i  input  XLEN  dmem read data, 1-cycle latency

Behaviour:
- Reset (rst_i=0, async): state=IDLE, rr_ptr=CPU-first, lock_cnt=0, rd_tag=none. All gnt, rvalid and mem_req outputs are 0; rdata outputs are 0.
- Grant is combinational within the cycle: exactly one of cpu_gnt_o/dbg_gnt_o may be 1. mem_req_o = cpu_gnt_o | dbg_gnt_o. mem_* fields come from the winner and are 0 when idle.
- No back-pressure from memory: every grant is an accepted access. A requester must hold its fields stable until its gnt.
- FSM states: IDLE, RR, DBG_LOCK, FORCE_CPU.
  - IDLE/RR, single requester: that requester wins.
  - IDLE/RR, both requesting: the rr_ptr side wins. rr_ptr flips to the other side after each contended grant.
  - IDLE/RR, dbg granted with dbg_lock_i=1: next state is DBG_LOCK, lock_cnt=1.
  - DBG_LOCK: only dbg can win; cpu_gnt_o=0 even if dbg is idle. Each dbg grant increments lock_cnt.
    - dbg_lock_i=0: go to RR; rr_ptr=CPU.
    - lock_cnt==LOCK_MAX while cpu_req_i=1: go to FORCE_CPU.
    - lock_cnt saturates at LOCK_MAX when CPU is not requesting.
  - FORCE_CPU: CPU wins unconditionally. Stay until cpu_gnt_o fires, then return to DBG_LOCK if dbg_lock_i=1, else RR. lock_cnt is cleared on exit.
- Read return: on a read grant, rd_tag records the owner (registered). The next cycle, that owner's rvalid_o=1 and its rdata_o = mem_rdata_i; the other side's rvalid is 0. Writes produce no rvalid.
- Back-to-back reads from alternating owners return in grant order, one per cycle.
- Reset asserted mid-operation: any pending rvalid is dropped, the lock is released, and the FSM returns to IDLE.
- Lock deassertion in the same cycle as a dbg grant: that grant still counts, and next state is RR.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined: adds 32-bit saturating counters cpu_stall_cnt_o and dbg_stall_cnt_o, plus force_cnt_o.
  - stall counters: cycles with req=1 and gnt=0, per side.
  - force_cnt_o: entries into FORCE_CPU.
  - All counters reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- cpu read addr 0x10 alone, mem_rdata_i=0xDEADBEEF -> cpu_gnt_o=1 in cycle 0; cpu_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1; dbg_rvalid_o=0.
- Both request continuously (no lock), 6 cycles -> grants alternate CPU,DBG,CPU,DBG,CPU,DBG; never both high.
- dbg lock held with continuous dbg and cpu requests, LOCK_MAX=4 -> 4 dbg grants, 1 cpu grant, then 4 dbg grants; force_cnt_o=2 after 10 grants (with stats enabled).
- Alternating reads cpu@0x0 / dbg@0x4 -> rvalid alternates cpu, dbg one cycle behind grants; each side receives its own mem_rdata_i.
- dbg write under lock, then lock dropped in the same cycle as a grant -> next cycle is in RR and CPU wins the contended grant.
- Assert rst_i low the cycle after a cpu read grant -> cpu_rvalid_o stays 0 and all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU LSU and a debug/loader master.
// Optional per-side stall and forced-slot counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_we_i,
    input  logic [XLEN/8-1:0]   cpu_be_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [XLEN-1:0]     cpu_wdata_i,
    input  logic                dbg_req_i,
    input  logic                dbg_we_i,
    input  logic [XLEN/8-1:0]   dbg_be_i,
    input  logic [ADDR_W-1:0]   dbg_addr_i,
    input  logic [XLEN-1:0]     dbg_wdata_i,
    input  logic                dbg_lock_i,
    output logic                cpu_gnt_o,
    output logic                dbg_gnt_o,
    output logic                cpu_rvalid_o,
    output logic                dbg_rvalid_o,
    output logic [XLEN-1:0]     cpu_rdata_o,
    output logic [XLEN-1:0]     dbg_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic [XLEN-1:0]     mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]         cpu_stall_cnt_o,
    output logic [31:0]         dbg_stall_cnt_o,
    output logic [31:0]         force_cnt_o
`endif
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, RR, DBG_LOCK, FORCE_CPU} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_rr_dbg, w_rr_dbg_nxt;
    logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic             r_rvld_cpu_p1, r_rvld_dbg_p1;
    logic             w_cpu_gnt, w_dbg_gnt;

    function automatic logic [CNT_W-1:0] lock_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_dbg_nxt   = r_rr_dbg;
        w_lock_cnt_nxt = r_lock_cnt;
        w_cpu_gnt      = 1'b0;
        w_dbg_gnt      = 1'b0;
        case (r_state)
            IDLE, RR: begin
                if (cpu_req_i && dbg_req_i) begin
                    w_cpu_gnt    = !r_rr_dbg;
                    w_dbg_gnt    = r_rr_dbg;
                    w_rr_dbg_nxt = !r_rr_dbg;
                end else begin
                    w_cpu_gnt = cpu_req_i;
                    w_dbg_gnt = dbg_req_i;
                end
                if (w_dbg_gnt && dbg_lock_i) begin
                    w_state_nxt    = DBG_LOCK;
                    w_lock_cnt_nxt = CNT_W'(1);
                end else if (w_cpu_gnt || w_dbg_gnt) begin
                    w_state_nxt = RR;
                end
            end
            DBG_LOCK: begin
                // A grant in the cycle the lock drops still counts toward the burst.
                w_dbg_gnt = dbg_req_i;
                if (w_dbg_gnt) w_lock_cnt_nxt = lock_inc(r_lock_cnt);
                if (!dbg_lock_i) begin
                    w_state_nxt    = RR;
                    w_rr_dbg_nxt   = 1'b0;
                    w_lock_cnt_nxt = '0;
                end else if (cpu_req_i && (w_lock_cnt_nxt == CNT_MAX)) begin
                    w_state_nxt = FORCE_CPU;
                end
            end
            FORCE_CPU: begin
                w_cpu_gnt = cpu_req_i;
                if (w_cpu_gnt) begin
                    w_lock_cnt_nxt = '0;
                    w_state_nxt    = dbg_lock_i ? DBG_LOCK : RR;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Grants are combinational, so hold them off while reset is asserted.
        if (!rst_i) begin
            w_cpu_gnt = 1'b0;
            w_dbg_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= IDLE;
            r_rr_dbg      <= 1'b0;
            r_lock_cnt    <= '0;
            r_rvld_cpu_p1 <= 1'b0;
            r_rvld_dbg_p1 <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_dbg      <= w_rr_dbg_nxt;
            r_lock_cnt    <= w_lock_cnt_nxt;
            r_rvld_cpu_p1 <= w_cpu_gnt && !cpu_we_i;
            r_rvld_dbg_p1 <= w_dbg_gnt && !dbg_we_i;
        end
    end

    assign cpu_gnt_o   = w_cpu_gnt;
    assign dbg_gnt_o   = w_dbg_gnt;
    assign mem_req_o   = w_cpu_gnt || w_dbg_gnt;
    assign mem_we_o    = (w_cpu_gnt && cpu_we_i) || (w_dbg_gnt && dbg_we_i);
    assign mem_be_o    = w_cpu_gnt ? cpu_be_i    : (w_dbg_gnt ? dbg_be_i    : '0);
    assign mem_addr_o  = w_cpu_gnt ? cpu_addr_i  : (w_dbg_gnt ? dbg_addr_i  : '0);
    assign mem_wdata_o = w_cpu_gnt ? cpu_wdata_i : (w_dbg_gnt ? dbg_wdata_i : '0);

    // p1: read data is steered to the side that owned the previous cycle's read grant.
    assign cpu_rvalid_o = r_rvld_cpu_p1;
    assign dbg_rvalid_o = r_rvld_dbg_p1;
    assign cpu_rdata_o  = r_rvld_cpu_p1 ? mem_rdata_i : '0;
    assign dbg_rdata_o  = r_rvld_dbg_p1 ? mem_rdata_i : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_cpu_stall, r_dbg_stall, r_force;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cpu_stall <= '0;
            r_dbg_stall <= '0;
            r_force     <= '0;
        end else begin
            if (cpu_req_i && !w_cpu_gnt) r_cpu_stall <= sat_inc32(r_cpu_stall);
            if (dbg_req_i && !w_dbg_gnt) r_dbg_stall <= sat_inc32(r_dbg_stall);
            if ((w_state_nxt == FORCE_CPU) && (r_state != FORCE_CPU)) r_force <= sat_inc32(r_force);
        end
    end

    assign cpu_stall_cnt_o = r_cpu_stall;
    assign dbg_stall_cnt_o = r_dbg_stall;
    assign force_cnt_o     = r_force;
`endif

endmodule
